// File: rtl/data_mem_responder.sv
//------------------------------------------------------------------------------
// data_mem_responder
//   Single-outstanding data-memory responder with wait states, byte-lane
//   steering and alignment checking in front of a word-organised RAM.
//   Optional feature macro: DMEM_MISALIGN_TRAP_EN (alignment faults reported).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module data_mem_responder #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int WAIT_CYCLES    = 0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [1:0]                size_i,
    input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic                      ready_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      err_o,
    output logic                      busy_o
);

    localparam int         WORDS     = 1 << (MEM_ADDR_WIDTH - 2);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                    state, next_state;
    logic [3:0]                cnt;
    logic                      accept;
    logic                      enter_resp;

    logic                      cap_we;
    logic [1:0]                cap_size;
    logic [MEM_ADDR_WIDTH-1:0] cap_addr;
    logic [31:0]               cap_wdata;

    logic                      cur_we;
    logic [1:0]                cur_size;
    logic [MEM_ADDR_WIDTH-1:0] cur_addr;
    logic [31:0]               cur_wdata;
    logic [MEM_ADDR_WIDTH-1:0] eff_addr;
    logic                      misalign;
    logic [1:0]                lane;
    logic [3:0]                byte_en;
    logic [31:0]               wdata_rep;
    logic [31:0]               rd_word;
    logic [31:0]               rd_shift;
    logic [31:0]               load_val;
    logic                      wr_en;

    logic [31:0]               mem [0:WORDS-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                cnt <= WAIT_LOAD;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        ready_o    = 1'b0;
        busy_o     = 1'b0;
        case (state)
            IDLE: begin
                if (req_i) begin
                    accept     = 1'b1;
                    next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                busy_o = 1'b1;
                if (cnt == 4'd1) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                ready_o = 1'b1;
                if (req_i) begin
                    accept     = 1'b1;
                    next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end else begin
                    busy_o     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        enter_resp = ((state == WAIT) && (cnt == 4'd1)) || (accept && (WAIT_CYCLES == 0));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cap_we    <= 1'b0;
            cap_size  <= 2'b00;
            cap_addr  <= '0;
            cap_wdata <= 32'd0;
        end else if (accept) begin
            cap_we    <= we_i;
            cap_size  <= size_i;
            cap_addr  <= addr_i;
            cap_wdata <= wdata_i;
        end
    end

    // With no wait states the response edge is also the accept edge, so the
    // live request inputs must drive the access directly.
    always_comb begin
        cur_we    = accept ? we_i    : cap_we;
        cur_size  = accept ? size_i  : cap_size;
        cur_addr  = accept ? addr_i  : cap_addr;
        cur_wdata = accept ? wdata_i : cap_wdata;
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        eff_addr = cur_addr;
        misalign = ((cur_size == 2'b01) && cur_addr[0]) ||
                   (cur_size[1] && (cur_addr[1:0] != 2'b00));
    end
`else
    always_comb begin
        misalign = 1'b0;
        eff_addr = cur_addr;
        if (cur_size == 2'b01) begin
            eff_addr[0] = 1'b0;
        end else if (cur_size[1]) begin
            eff_addr[1:0] = 2'b00;
        end
    end
`endif

    always_comb begin
        lane = eff_addr[1:0];
        case (cur_size)
            2'b00: begin
                byte_en   = 4'b0001 << lane;
                wdata_rep = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                byte_en   = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{cur_wdata[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                wdata_rep = cur_wdata;
            end
        endcase
        rd_word  = mem[eff_addr[MEM_ADDR_WIDTH-1:2]];
        rd_shift = rd_word >> {lane, 3'b000};
        case (cur_size)
            2'b00:   load_val = {24'd0, rd_shift[7:0]};
            2'b01:   load_val = {16'd0, rd_shift[15:0]};
            default: load_val = rd_shift;
        endcase
        wr_en = enter_resp && cur_we && !misalign;
    end

    // RAM contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[eff_addr[MEM_ADDR_WIDTH-1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_o <= '0;
            err_o   <= 1'b0;
        end else if (enter_resp) begin
            err_o   <= misalign;
            rdata_o <= (cur_we || misalign) ? '0 : load_val;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
//------------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed bench: one instance with no wait states, one with three.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with WAIT_CYCLES = 0
    logic        rstn0, req0, we0, ready0, err0, busy0;
    logic [1:0]  size0;
    logic [9:0]  addr0;
    logic [31:0] wdata0, rdata0;

    // Instance with WAIT_CYCLES = 3
    logic        rstn3, req3, we3, ready3, err3, busy3;
    logic [1:0]  size3;
    logic [9:0]  addr3;
    logic [31:0] wdata3, rdata3;

    data_mem_responder #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rstn(rstn0), .req_i(req0), .we_i(we0), .size_i(size0),
        .addr_i(addr0), .wdata_i(wdata0), .ready_o(ready0), .rdata_o(rdata0),
        .err_o(err0), .busy_o(busy0)
    );

    data_mem_responder #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rstn(rstn3), .req_i(req3), .we_i(we3), .size_i(size3),
        .addr_i(addr3), .wdata_i(wdata3), .ready_o(ready3), .rdata_o(rdata3),
        .err_o(err3), .busy_o(busy3)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vec [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request and return the number of cycles until ready (0 = timeout).
    task automatic do_req0(input logic w, input logic [1:0] s, input logic [9:0] a,
                           input logic [31:0] d, output int lat);
        @(negedge clk);
        we0 = w; size0 = s; addr0 = a; wdata0 = d; req0 = 1'b1;
        @(posedge clk);
        #1 req0 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ready0) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_req3(input logic w, input logic [1:0] s, input logic [9:0] a,
                           input logic [31:0] d, output int lat);
        @(negedge clk);
        we3 = w; size3 = s; addr3 = a; wdata3 = d; req3 = 1'b1;
        @(posedge clk);
        #1 req3 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ready3) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int pulses;

        vec[0]  = '{1'b1, 2'b10, 10'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vec[1]  = '{1'b0, 2'b10, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vec[2]  = '{1'b1, 2'b10, 10'h010, 32'h11223344, 32'h00000000, 1'b0};
        vec[3]  = '{1'b1, 2'b00, 10'h013, 32'h000000A5, 32'h00000000, 1'b0};
        vec[4]  = '{1'b0, 2'b10, 10'h010, 32'h0,        32'hA5223344, 1'b0};
        vec[5]  = '{1'b0, 2'b01, 10'h012, 32'h0,        32'h0000A522, 1'b0};
        vec[6]  = '{1'b0, 2'b00, 10'h011, 32'h0,        32'h00000033, 1'b0};
        vec[7]  = '{1'b1, 2'b10, 10'h014, 32'h55667788, 32'h00000000, 1'b0};
        vec[8]  = '{1'b1, 2'b01, 10'h016, 32'h1234ABCD, 32'h00000000, 1'b0};
        vec[9]  = '{1'b0, 2'b10, 10'h014, 32'h0,        32'hABCD7788, 1'b0};
        vec[10] = '{1'b0, 2'b01, 10'h014, 32'h0,        32'h00007788, 1'b0};
        vec[11] = '{1'b0, 2'b00, 10'h017, 32'h0,        32'h000000AB, 1'b0};
        vec[12] = '{1'b0, 2'b11, 10'h014, 32'h0,        32'hABCD7788, 1'b0};
        vec[13] = '{1'b1, 2'b10, 10'h020, 32'h00000000, 32'h00000000, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
        vec[14] = '{1'b1, 2'b10, 10'h021, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vec[15] = '{1'b0, 2'b10, 10'h020, 32'h0,        32'h00000000, 1'b0};
        vec[16] = '{1'b0, 2'b01, 10'h011, 32'h0,        32'h00000000, 1'b1};
`else
        vec[14] = '{1'b1, 2'b10, 10'h021, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vec[15] = '{1'b0, 2'b10, 10'h020, 32'h0,        32'hFFFFFFFF, 1'b0};
        vec[16] = '{1'b0, 2'b01, 10'h011, 32'h0,        32'h00003344, 1'b0};
`endif
        vec[17] = '{1'b0, 2'b00, 10'h013, 32'h0,        32'h000000A5, 1'b0};

        rstn0 = 1'b0; req0 = 1'b0; we0 = 1'b0; size0 = 2'b00; addr0 = '0; wdata0 = '0;
        rstn3 = 1'b0; req3 = 1'b0; we3 = 1'b0; size3 = 2'b00; addr3 = '0; wdata3 = '0;
        repeat (2) @(negedge clk);
        rstn0 = 1'b1;
        rstn3 = 1'b1;

        // Idle after reset
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready", {31'd0, ready0}, 32'd0);
            chk("idle_err",   {31'd0, err0},   32'd0);
            chk("idle_busy",  {31'd0, busy0},  32'd0);
            chk("idle_rdata", rdata0,          32'd0);
        end
        chk("idle_busy3", {31'd0, busy3}, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            do_req0(vec[i].we, vec[i].size, vec[i].addr, vec[i].wdata, lat);
            chk($sformatf("v%0d_latency", i), lat, 32'd1);
            chk($sformatf("v%0d_busy", i), {31'd0, busy0}, 32'd1);
            chk($sformatf("v%0d_err", i), {31'd0, err0}, {31'd0, vec[i].exp_err});
            chk($sformatf("v%0d_rdata", i), rdata0, vec[i].exp_rdata);
        end

        // Back-to-back: store then load accepted in the RESP cycle
        @(negedge clk);
        we0 = 1'b1; size0 = 2'b10; addr0 = 10'h030; wdata0 = 32'hCAFEF00D; req0 = 1'b1;
        @(negedge clk);
        chk("b2b_ready1", {31'd0, ready0}, 32'd1);
        we0 = 1'b0;
        #1 chk("b2b_busy1", {31'd0, busy0}, 32'd0);
        @(negedge clk);
        chk("b2b_ready2", {31'd0, ready0}, 32'd1);
        chk("b2b_rdata2", rdata0, 32'hCAFEF00D);
        req0 = 1'b0;
        #1 chk("b2b_busy2", {31'd0, busy0}, 32'd1);
        @(negedge clk);
        chk("b2b_ready_off", {31'd0, ready0}, 32'd0);
        chk("b2b_rdata_hold", rdata0, 32'hCAFEF00D);

        // Wait states: seed a word, then cycle-exact load
        do_req3(1'b1, 2'b10, 10'h040, 32'h0BADF00D, lat);
        chk("w3_store_latency", lat, 32'd4);
        @(negedge clk);
        we3 = 1'b0; size3 = 2'b10; addr3 = 10'h040; req3 = 1'b1;
        @(posedge clk);
        #1 req3 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("w3_ready_c%0d", k), {31'd0, ready3}, (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("w3_busy_c%0d", k), {31'd0, busy3}, (k <= 4) ? 32'd1 : 32'd0);
        end
        chk("w3_rdata", rdata3, 32'h0BADF00D);

        // Reset during WAIT discards the pending store
        @(negedge clk);
        we3 = 1'b1; size3 = 2'b10; addr3 = 10'h040; wdata3 = 32'h12345678; req3 = 1'b1;
        @(posedge clk);
        #1 req3 = 1'b0;
        @(negedge clk);
        chk("rst_busy_before", {31'd0, busy3}, 32'd1);
        rstn3 = 1'b0;
        #1;
        chk("rst_busy_async", {31'd0, busy3}, 32'd0);
        chk("rst_rdata_async", rdata3, 32'd0);
        #1 rstn3 = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ready3) pulses++;
        end
        chk("rst_no_ready", pulses, 32'd0);
        do_req3(1'b0, 2'b10, 10'h040, 32'h0, lat);
        chk("rst_load_latency", lat, 32'd4);
        chk("rst_load_old", rdata3, 32'h0BADF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
